myca_run_ctrl: RTL and testbench

- Run/halt/single-step controller for the MycaII core.
- Generates the instruction-rate tick and gates it into a one-cycle core enable.
- Provides a PC breakpoint and an executed-instruction counter.
- Sits between the board clock and the MycaII/ROM pair; it replaces the free-running 1 s clock with controlled stepping for bring-up and debug.

---
 rtl/myca_run_ctrl.sv | 152 +++++++++++++++
 tb/tb_myca_run_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/myca_run_ctrl.sv
// Run/halt/single-step controller for MycaII: instruction tick, gated core enable,
// PC breakpoint and instruction counter. Optional PC-stall watchdog under MYCA_WDOG_EN.
module myca_run_ctrl #(
    parameter int unsigned DIV      = 50000000,
    parameter int unsigned WDOG_LIM = 255
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        run,
    input  logic        halt,
    input  logic        step,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  pc,
    output logic        core_en,
    output logic        tick,
    output logic [1:0]  state,
    output logic        bp_hit,
    output logic        wdog_trip,
    output logic [15:0] instr_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } st_t;

    localparam logic [25:0] DIV_LAST = 26'(DIV - 1);

    if (DIV < 2 || DIV > 67108864 || WDOG_LIM > 255) begin : g_param_chk
        $error("myca_run_ctrl: DIV or WDOG_LIM out of range");
    end

    st_t         state_q, state_d;
    logic [25:0] div_cnt;
    logic        skip_bp, skip_d;
    logic        flags_clr, stop_now;
    logic        bp_stop, wdog_stop, run_stop;

    always_ff @(posedge ck) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 26'd1;
            tick    <= 1'b0;
        end
    end

    // skip_bp lets a resume from a breakpoint execute the instruction at bp_addr once
    assign bp_stop  = bp_en & (pc == bp_addr) & ~skip_bp;
    assign run_stop = bp_stop | wdog_stop;
    assign core_en  = tick & ~halt & ~rst &
                      ((state_q == ST_STEP) | ((state_q == ST_RUN) & ~run_stop));
    assign state    = state_q;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_bp;
        flags_clr = 1'b0;
        stop_now  = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (!halt) begin
                    if (step) begin
                        state_d   = ST_STEP;
                        flags_clr = 1'b1;
                    end else if (run) begin
                        state_d   = ST_RUN;
                        flags_clr = 1'b1;
                        skip_d    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (tick && run_stop) begin
                    state_d  = ST_HALT;
                    stop_now = 1'b1;
                end else if (core_en) begin
                    skip_d = 1'b0;
                end
            end
            ST_STEP: begin
                if (halt || core_en) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q   <= ST_HALT;
            skip_bp   <= 1'b1;
            bp_hit    <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            skip_bp <= skip_d;
            if (flags_clr)
                bp_hit <= 1'b0;
            else if (stop_now && bp_stop)
                bp_hit <= 1'b1;
            if (core_en)
                instr_cnt <= instr_cnt + 16'd1;
        end
    end

`ifdef MYCA_WDOG_EN
    localparam logic [7:0] WDOG_LIM8 = 8'(WDOG_LIM);

    logic [7:0] same_cnt;
    logic [7:0] last_pc;
    logic       wdog_q;

    assign wdog_stop = (same_cnt >= WDOG_LIM8);
    assign wdog_trip = wdog_q;

    // same_cnt==0 means no reference pc yet, so the first enable starts a run of one
    always_ff @(posedge ck) begin
        if (rst || state_q == ST_HALT) begin
            same_cnt <= '0;
        end else if (core_en && state_q == ST_RUN) begin
            if (same_cnt == 8'd0 || pc == last_pc) begin
                if (same_cnt != 8'hFF) same_cnt <= same_cnt + 8'd1;
            end else begin
                same_cnt <= '0;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (core_en) last_pc <= pc;
    end

    always_ff @(posedge ck) begin
        if (rst || flags_clr)
            wdog_q <= 1'b0;
        else if (stop_now && wdog_stop)
            wdog_q <= 1'b1;
    end
`else
    assign wdog_stop = 1'b0;
    assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_myca_run_ctrl.sv
// Directed bench for myca_run_ctrl (DIV=4, WDOG_LIM=3); expectations follow MYCA_WDOG_EN.
module tb_myca_run_ctrl;

    localparam int DIV = 4;

    logic        ck;
    logic        rst;
    logic        run, halt, step, bp_en;
    logic [7:0]  bp_addr, pc;
    logic        core_en, tick, bp_hit, wdog_trip;
    logic [1:0]  state;
    logic [15:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        run, halt, step, bp_en;
        logic [7:0]  bp_addr, pc;
        logic        exp_en;
        logic [1:0]  exp_state;
        logic        exp_bp, exp_wd;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    myca_run_ctrl #(.DIV(DIV), .WDOG_LIM(3)) dut (
        .ck(ck), .rst(rst), .run(run), .halt(halt), .step(step),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .core_en(core_en), .tick(tick), .state(state),
        .bp_hit(bp_hit), .wdog_trip(wdog_trip), .instr_cnt(instr_cnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic vec_t mk(logic r, logic h, logic s, logic be, logic [7:0] ba,
                                logic [7:0] p, logic en, logic [1:0] st, logic bp,
                                logic wd, logic [15:0] cnt);
        vec_t v;
        v.run = r; v.halt = h; v.step = s; v.bp_en = be; v.bp_addr = ba; v.pc = p;
        v.exp_en = en; v.exp_state = st; v.exp_bp = bp; v.exp_wd = wd; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ck);
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 2 * DIV + 2) begin
            cyc();
            n++;
        end
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: tick=%0b after %0d cycles, expected 1", tick, n);
        end
    endtask

    // Drive one row in a tick cycle, check the enable, then the registered results
    task automatic apply(input vec_t v, input int idx);
        wait_tick();
        run = v.run; halt = v.halt; step = v.step;
        bp_en = v.bp_en; bp_addr = v.bp_addr; pc = v.pc;
        #1;
        chk($sformatf("row%0d core_en", idx), core_en, v.exp_en);
        cyc();
        chk($sformatf("row%0d state", idx), state, v.exp_state);
        chk($sformatf("row%0d bp_hit", idx), bp_hit, v.exp_bp);
        chk($sformatf("row%0d wdog_trip", idx), wdog_trip, v.exp_wd);
        chk($sformatf("row%0d instr_cnt", idx), instr_cnt, v.exp_cnt);
        run = 1'b0; halt = 1'b0; step = 1'b0;
    endtask

    initial begin
        int en_seen;

        tbl_a.push_back(mk(1,0,0,0,8'h00,8'h00, 0,2'd1,0,0,16'd0));
        for (int i = 1; i <= 10; i++)
            tbl_a.push_back(mk(0,0,0,0,8'h00,8'(i), 1,2'd1,0,0,16'(i)));
        for (int i = 0; i <= 4; i++)
            tbl_a.push_back(mk(0,0,0,1,8'h05,8'(i), 1,2'd1,0,0,16'(11 + i)));
        tbl_a.push_back(mk(0,0,0,1,8'h05,8'h05, 0,2'd0,1,0,16'd15));
        tbl_a.push_back(mk(1,0,0,1,8'h05,8'h05, 0,2'd1,0,0,16'd15));
        tbl_a.push_back(mk(0,0,0,1,8'h05,8'h05, 1,2'd1,0,0,16'd16));
        tbl_a.push_back(mk(0,0,0,1,8'h05,8'h06, 1,2'd1,0,0,16'd17));
        tbl_a.push_back(mk(0,0,0,1,8'h05,8'h05, 0,2'd0,1,0,16'd17));
        tbl_a.push_back(mk(1,0,1,1,8'h05,8'h05, 0,2'd2,0,0,16'd17));
        tbl_a.push_back(mk(0,0,0,1,8'h05,8'h05, 1,2'd0,0,0,16'd18));
        tbl_a.push_back(mk(0,0,0,1,8'h05,8'h05, 0,2'd0,0,0,16'd18));
        tbl_a.push_back(mk(1,0,0,0,8'h00,8'h07, 0,2'd1,0,0,16'd18));
        tbl_a.push_back(mk(0,0,0,0,8'h00,8'h07, 1,2'd1,0,0,16'd19));
        tbl_a.push_back(mk(0,1,0,0,8'h00,8'h08, 0,2'd0,0,0,16'd19));
        tbl_a.push_back(mk(1,0,0,0,8'h00,8'h09, 0,2'd1,0,0,16'd19));

        tbl_b.push_back(mk(1,0,0,0,8'h00,8'h10, 0,2'd1,0,0,16'd0));
        for (int i = 1; i <= 3; i++)
            tbl_b.push_back(mk(0,0,0,0,8'h00,8'h10, 1,2'd1,0,0,16'(i)));
`ifdef MYCA_WDOG_EN
        tbl_b.push_back(mk(0,0,0,0,8'h00,8'h10, 0,2'd0,0,1,16'd3));
        tbl_b.push_back(mk(0,0,0,0,8'h00,8'h10, 0,2'd0,0,1,16'd3));
`else
        tbl_b.push_back(mk(0,0,0,0,8'h00,8'h10, 1,2'd1,0,0,16'd4));
        tbl_b.push_back(mk(0,0,0,0,8'h00,8'h10, 1,2'd1,0,0,16'd5));
`endif

        rst = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0;
        bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00;
        cyc();
        cyc();
        chk("reset state", state, 2'd0);
        chk("reset tick", tick, 1'b0);
        chk("reset core_en", core_en, 1'b0);
        chk("reset bp_hit", bp_hit, 1'b0);
        chk("reset wdog_trip", wdog_trip, 1'b0);
        chk("reset instr_cnt", instr_cnt, 16'd0);

        // Idle HALT: tick lands on the 4th, 8th and 12th edge after reset release
        rst = 1'b0;
        en_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            en_seen += int'(core_en);
            cyc();
            if (k == 3 || k == 5) chk($sformatf("idle tick@%0d", k), tick, 1'b0);
            if (k % 4 == 0)       chk($sformatf("idle tick@%0d", k), tick, 1'b1);
        end
        chk("idle core_en pulses", en_seen, 0);
        chk("idle state", state, 2'd0);
        chk("idle instr_cnt", instr_cnt, 16'd0);

        foreach (tbl_a[i]) apply(tbl_a[i], i);

        // Reset in a tick cycle while running: enable held off, everything back to reset
        wait_tick();
        rst = 1'b1;
        #1;
        chk("rst core_en", core_en, 1'b0);
        cyc();
        chk("rst state", state, 2'd0);
        chk("rst tick", tick, 1'b0);
        chk("rst bp_hit", bp_hit, 1'b0);
        chk("rst wdog_trip", wdog_trip, 1'b0);
        chk("rst instr_cnt", instr_cnt, 16'd0);
        rst = 1'b0;
        #1;
        chk("post-rst core_en", core_en, 1'b0);

        foreach (tbl_b[i]) apply(tbl_b[i], 100 + i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
